switch_setting_sequencer: RTL and testbench

//  Sequences the mod-80/mod-81 divider pair that turns the 13-bit switch word W into PWM

---
 rtl/switch_pkg.sv | 33 +++
 rtl/word_debounce.sv | 55 +++++
 rtl/switch_setting_sequencer.sv | 166 ++++++++++++++++
 tb/tb_switch_setting_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : switch_pkg
//  Purpose : Shared types and constants for the switch-word sequencer and the
//            mod-80 / mod-81 divider pair it drives.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package switch_pkg;

    // Widths of the switch word and of the divider remainders
    localparam int W_WIDTH   = 13;
    localparam int R_WIDTH   = 7;

    // Divisors implemented by the divider wrapper (A = W mod 80, B = W mod 81)
    localparam int DIVISOR_A = 80;
    localparam int DIVISOR_B = 81;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } state_e;

    // Larger of two integers, used to size shared counters
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/word_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : word_debounce
//  Purpose : Tracks a multi-bit input word and flags when it has held the same
//            value for STABLE_CYCLES consecutive cycles.
//  Ports   : clk      - rising-edge clock
//            reset_n  - asynchronous active-low reset
//            din      - raw input word (may change any cycle)
//            cand     - candidate word (din delayed one cycle)
//            stable   - high while cand has been unchanged for STABLE_CYCLES
//  Rev     : 1.0  initial release
// ============================================================================
module word_debounce #(
    parameter int WIDTH         = 13,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cand,
    output logic             stable
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] cand_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Counter restarts whenever the input disagrees with the candidate and
    // saturates once the stability window has been reached.
    always_comb begin
        cnt_d = cnt_q;
        if (din != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= din;
            cnt_q  <= cnt_d;
        end
    end

    assign cand   = cand_q;
    assign stable = (cnt_q == CW'(STABLE_CYCLES));

endmodule : word_debounce
`default_nettype wire

// File: rtl/switch_setting_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : switch_setting_sequencer
//  Purpose : Debounces the switch word W, loads it into the mod-80/mod-81
//            divider pair once per accepted word, waits for the dividers, then
//            latches the remainders as PWM counts A/B and enables gen_PWM.
//  Ports   : clk, reset_n        - clock, asynchronous active-low reset
//            W                   - raw switch word
//            div_W / div_load    - word and one-cycle load pulse to dividers
//            div_done/div_A/div_B- divider completion and remainders
//            A / B               - latched PWM counts
//            pwm_en / pwm_load   - PWM enable, one-cycle update pulse
//            busy                - high outside IDLE
//            timeout             - sticky divider-timeout error
//  Rev     : 1.0  initial release
// ============================================================================
module switch_setting_sequencer
    import switch_pkg::*;
#(
    parameter int W_WIDTH       = switch_pkg::W_WIDTH,
    parameter int R_WIDTH       = switch_pkg::R_WIDTH,
    parameter int STABLE_CYCLES = 4,
    parameter int BLANK_CYCLES  = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [W_WIDTH-1:0] W,
    output logic [W_WIDTH-1:0] div_W,
    output logic               div_load,
    input  logic               div_done,
    input  logic [R_WIDTH-1:0] div_A,
    input  logic [R_WIDTH-1:0] div_B,
    output logic [R_WIDTH-1:0] A,
    output logic [R_WIDTH-1:0] B,
    output logic               pwm_en,
    output logic               pwm_load,
    output logic               busy,
    output logic               timeout
);

    localparam int CNT_W = $clog2(max2(STABLE_CYCLES, TIMEOUT) + 1);

    state_e             state_q, state_d;
    logic [W_WIDTH-1:0] div_W_q, div_W_d;
    logic [R_WIDTH-1:0] A_q, A_d;
    logic [R_WIDTH-1:0] B_q, B_d;
    logic               valid_q, valid_d;
    logic               pending_q, pending_d;
    logic               timeout_q, timeout_d;
    logic               pwm_en_q, pwm_en_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;

    logic [W_WIDTH-1:0] cand;
    logic               stable;
    logic               accept;

    word_debounce #(
        .WIDTH        (W_WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (W),
        .cand   (cand),
        .stable (stable)
    );

    // A word is accepted only if it differs from what the dividers already hold
    assign accept = stable && (cand != div_W_q);

    always_comb begin
        state_d   = state_q;
        div_W_d   = div_W_q;
        A_d       = A_q;
        B_d       = B_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        timeout_d = timeout_q;
        wcnt_d    = wcnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Word is presented together with the load pulse
                    div_W_d = cand;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pending_d = 1'b0;
                wcnt_d    = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // div_W is frozen while the dividers run; remember the request
                if (accept) begin
                    pending_d = 1'b1;
                end
                // Early done may be left over from the previous word
                if ((wcnt_q >= CNT_W'(BLANK_CYCLES)) && div_done) begin
                    state_d = LATCH;
                end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                A_d       = div_A;
                B_d       = div_B;
                valid_d   = 1'b1;
                timeout_d = 1'b0;
                if (pending_q) begin
                    div_W_d = cand;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered enable: follows the state being entered
        pwm_en_d = valid_d && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_W_q   <= '0;
            A_q       <= '0;
            B_q       <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            pwm_en_q  <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_W_q   <= div_W_d;
            A_q       <= A_d;
            B_q       <= B_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            pwm_en_q  <= pwm_en_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign div_W    = div_W_q;
    assign div_load = (state_q == LOAD);
    assign pwm_load = (state_q == LATCH);
    assign busy     = (state_q != IDLE);
    assign A        = A_q;
    assign B        = B_q;
    assign pwm_en   = pwm_en_q;
    assign timeout  = timeout_q;

endmodule : switch_setting_sequencer
`default_nettype wire

// File: tb/tb_switch_setting_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_switch_setting_sequencer
//  Purpose : Self-checking bench for switch_setting_sequencer with a
//            behavioural divider model (normal / done stuck high / never done).
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_switch_setting_sequencer;
    import switch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [12:0] W;
    logic [12:0] div_W;
    logic        div_load;
    logic        div_done;
    logic [6:0]  div_A;
    logic [6:0]  div_B;
    logic [6:0]  A;
    logic [6:0]  B;
    logic        pwm_en;
    logic        pwm_load;
    logic        busy;
    logic        timeout;

    switch_setting_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .W       (W),
        .div_W   (div_W),
        .div_load(div_load),
        .div_done(div_done),
        .div_A   (div_A),
        .div_B   (div_B),
        .A       (A),
        .B       (B),
        .pwm_en  (pwm_en),
        .pwm_load(pwm_load),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider model ----------------
    int          mdl_n    = 14;
    int          mdl_mode = 0;   // 0 normal, 1 done stuck high, 2 never done
    logic [12:0] mdl_w    = '0;
    int          mdl_cnt  = 1000;

    always @(posedge clk) begin
        if (div_load) begin
            mdl_w   <= div_W;
            mdl_cnt <= 0;
        end else if (mdl_cnt < 1000) begin
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    assign div_done = (mdl_mode == 1) ? 1'b1 :
                      (mdl_mode == 2) ? 1'b0 : (mdl_cnt >= mdl_n);
    assign div_A = 7'(mdl_w % 13'(DIVISOR_A));
    assign div_B = 7'(mdl_w % 13'(DIVISOR_B));

    // ---------------- monitor ----------------
    int cyc    = 0;
    int dl_cnt = 0;
    int dl_cyc = -1;
    int pl_cnt = 0;
    int pl_cyc = -1;
    int to_cyc = -1;
    int en_hi  = 0;
    logic        to_prev = 1'b0;
    logic [12:0] load_w  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (div_load) begin
            dl_cnt = dl_cnt + 1;
            if (dl_cyc < 0) dl_cyc = cyc;
            load_w = div_W;
        end
        if (pwm_load) begin
            pl_cnt = pl_cnt + 1;
            if (pl_cyc < 0) pl_cyc = cyc;
        end
        if (timeout && !to_prev && to_cyc < 0) to_cyc = cyc;
        to_prev = timeout;
        if (pwm_en) en_hi = en_hi + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        dl_cnt = 0; dl_cyc = -1;
        pl_cnt = 0; pl_cyc = -1;
        to_cyc = -1; en_hi = 0;
    endtask

    // Apply a word, wait for its conversion (or timeout) and check everything
    task automatic run_word(input string name, input logic [12:0] w, input int n,
                            input int mode, input int ea, input int eb,
                            input int eto, input int lat);
        int cyc0;
        int ev;
        mdl_n    = n;
        mdl_mode = mode;
        clear_mon();
        W    = w;
        cyc0 = cyc + 1;
        for (int i = 0; i < 300; i++) begin
            if ((eto != 0) ? (to_cyc >= 0) : (pl_cyc >= 0)) break;
            tick();
        end
        tick();
        ev = (eto != 0) ? to_cyc : pl_cyc;
        check({name, ".load_lat"}, dl_cyc - cyc0, 5);
        check({name, ".load_cnt"}, dl_cnt, 1);
        check({name, ".event_lat"}, ev - cyc0, lat);
        check({name, ".pwm_load_cnt"}, pl_cnt, (eto != 0) ? 0 : 1);
        check({name, ".A"}, int'(A), ea);
        check({name, ".B"}, int'(B), eb);
        check({name, ".timeout"}, int'(timeout), eto);
        check({name, ".pwm_en"}, int'(pwm_en), (eto != 0) ? 0 : 1);
        check({name, ".busy"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [12:0] w;
        int          n;
        int          mode;
        int          ea;
        int          eb;
        int          eto;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // word, divider cycles, mode, A, B, timeout, cycles to pwm_load/timeout
        vecs[0] = '{13'd1000, 14, 0, 40, 28, 0, 21};
        vecs[1] = '{13'd1,     2, 0,  1,  1, 0,  9};
        vecs[2] = '{13'd80,    5, 0,  0, 80, 0, 12};
        vecs[3] = '{13'd4321,  0, 1,  1, 28, 0,  9};  // done stuck high: blanking
        vecs[4] = '{13'd2222,  0, 2,  1, 28, 1, 70};  // never done: timeout, A/B kept
        vecs[5] = '{13'd6561,  3, 0,  1,  0, 0, 10};  // good word clears timeout
        vecs[6] = '{13'd8191, 20, 0, 31, 10, 0, 27};

        reset_n = 1'b0;
        W       = '0;
        tick();
        tick();
        check("rst.div_W", int'(div_W), 0);
        check("rst.div_load", int'(div_load), 0);
        check("rst.A", int'(A), 0);
        check("rst.B", int'(B), 0);
        check("rst.pwm_en", int'(pwm_en), 0);
        check("rst.pwm_load", int'(pwm_load), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.timeout", int'(timeout), 0);

        // W = 0 out of reset never converts
        reset_n = 1'b1;
        clear_mon();
        repeat (100) tick();
        check("idle0.load_cnt", dl_cnt, 0);
        check("idle0.pwm_en_cycles", en_hi, 0);
        check("idle0.busy", int'(busy), 0);
        check("idle0.A", int'(A), 0);

        foreach (vecs[k]) begin
            run_word($sformatf("vec%0d", k), vecs[k].w, vecs[k].n, vecs[k].mode,
                     vecs[k].ea, vecs[k].eb, vecs[k].eto, vecs[k].lat);
        end

        // Glitches shorter than the stability window, ending at the held word
        mdl_mode = 0;
        mdl_n    = 4;
        clear_mon();
        W = 13'd1000; tick();
        W = 13'd1001; tick();
        W = 13'd1000; tick();
        W = 13'd8191;
        repeat (20) tick();
        check("glitch.load_cnt", dl_cnt, 0);
        check("glitch.A", int'(A), 31);
        check("glitch.B", int'(B), 10);
        check("glitch.pwm_en", int'(pwm_en), 1);
        check("glitch.div_W", int'(div_W), 8191);

        // Changes during WAIT: only the last stable word is converted afterwards
        mdl_n = 14;
        clear_mon();
        W = 13'd5000;
        for (int i = 0; i < 50 && dl_cnt < 1; i++) tick();
        check("pend.first_load", dl_cnt, 1);
        en_hi = 0;
        repeat (2) tick();
        W = 13'd3000;
        repeat (5) tick();
        W = 13'd8191;
        for (int i = 0; i < 100 && pl_cnt < 1; i++) tick();
        tick();
        check("pend.A1", int'(A), 40);
        check("pend.B1", int'(B), 59);
        check("pend.pwm_en_after1", int'(pwm_en), 0);
        for (int i = 0; i < 100 && pl_cnt < 2; i++) tick();
        check("pend.pwm_en_cycles_between", en_hi, 0);
        tick();
        check("pend.A2", int'(A), 31);
        check("pend.B2", int'(B), 10);
        check("pend.pwm_en_after2", int'(pwm_en), 1);
        check("pend.load_cnt", dl_cnt, 2);
        check("pend.load_word", int'(load_w), 8191);

        // Reset in the middle of WAIT
        clear_mon();
        W = 13'd1234;
        for (int i = 0; i < 50 && dl_cnt < 1; i++) tick();
        repeat (3) tick();
        check("midrst.busy_before", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.div_W", int'(div_W), 0);
        check("midrst.A", int'(A), 0);
        check("midrst.B", int'(B), 0);
        check("midrst.busy", int'(busy), 0);
        check("midrst.pwm_en", int'(pwm_en), 0);
        tick();
        reset_n = 1'b1;
        run_word("midrst_reconv", 13'd1234, 14, 0, 34, 19, 0, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_switch_setting_sequencer
`default_nettype wire
